// File: rtl/rf_stream_pkg.sv
// Shared definitions for the register-file stream port.
// Contents: default widths, FSM state constants, transfer mode enum.
package rf_stream_pkg;

  localparam int DEFAULT_DATA_W = 32;
  localparam int DEFAULT_ADDR_W = 5;

  // state   | meaning
  // IDLE    | waiting for start_i
  // DUMP    | reading registers into the output stream register
  // DRAIN   | last word loaded, waiting for its handshake
  // LOAD    | accepting input words and writing them to the register file
  // DONE    | one-cycle completion pulse (err_o too if the range was empty)
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_DUMP  = 3'd1;
  localparam logic [2:0] ST_DRAIN = 3'd2;
  localparam logic [2:0] ST_LOAD  = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  typedef enum logic {
    MODE_DUMP = 1'b0,
    MODE_LOAD = 1'b1
  } mode_t;

endpackage

// File: rtl/rf_addr_seq.sv
// Address sequencer shared by dump and load: holds the current pointer and
// the inclusive end address, and flags when the pointer sits on the end.
// Ports:
//   clk, rst         clock, async active-high reset
//   load             capture first_addr into ptr and last_addr as the end
//   inc              advance ptr by one
//   first_addr       start of range
//   last_addr        inclusive end of range
//   ptr              current address
//   is_last          ptr equals the captured end address
module rf_addr_seq
  import rf_stream_pkg::*;
#(
  parameter int ADDR_W = DEFAULT_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              inc,
  input  logic [ADDR_W-1:0] first_addr,
  input  logic [ADDR_W-1:0] last_addr,
  output logic [ADDR_W-1:0] ptr,
  output logic              is_last
);

  logic [ADDR_W-1:0] last_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr    <= '0;
      last_q <= '0;
    end else if (load) begin
      ptr    <= first_addr;
      last_q <= last_addr;
    end else if (inc) begin
      ptr    <= ptr + 1'b1;
    end
  end

  // Completion is an equality compare, so a range ending at the top address
  // never relies on the pointer wrapping.
  assign is_last = (ptr == last_q);

endmodule

// File: rtl/rf_stream_port.sv
// Sequencing initiator for the register file. Walks an inclusive address
// range, either dumping registers onto a valid/ready output stream or loading
// words from a valid/ready input stream into consecutive registers.
// Ports:
//   clk_i, rst_i                       clock, async active-high reset
//   start_i, mode_i                    start command and mode (0 dump, 1 load)
//   first_addr_i, last_addr_i          inclusive range, sampled with start_i
//   busy_o, done_o, err_o              status; err_o marks an empty range
//   rf_we_o, rf_waddr_o, rf_wdata_o    register file write port
//   rf_raddr_o, rf_rdata_i             register file read port (combinational)
//   s_valid_i, s_ready_o, s_data_i     load input stream
//   m_valid_o, m_ready_i, m_data_o     dump output stream
module rf_stream_port
  import rf_stream_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int ADDR_W = DEFAULT_ADDR_W
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              mode_i,
  input  logic [ADDR_W-1:0] first_addr_i,
  input  logic [ADDR_W-1:0] last_addr_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o,
  output logic              rf_we_o,
  output logic [ADDR_W-1:0] rf_waddr_o,
  output logic [DATA_W-1:0] rf_wdata_o,
  output logic [ADDR_W-1:0] rf_raddr_o,
  input  logic [DATA_W-1:0] rf_rdata_i,
  input  logic              s_valid_i,
  output logic              s_ready_o,
  input  logic [DATA_W-1:0] s_data_i,
  output logic              m_valid_o,
  input  logic              m_ready_i,
  output logic [DATA_W-1:0] m_data_o
);

  logic [2:0]        state;
  logic              err_q;
  logic              m_valid_q;
  logic [DATA_W-1:0] m_data_q;
  logic [ADDR_W-1:0] ptr;
  logic              is_last;
  logic              seq_load;
  logic              seq_inc;
  logic              beat_load;
  logic              s_xfer;
  logic              empty_range;

  assign empty_range = (first_addr_i > last_addr_i);
  assign seq_load    = (state == ST_IDLE) && start_i;

  // The output register takes a new word when it is empty or when its
  // current word is handed off on this same edge.
  assign beat_load = (state == ST_DUMP) && (!m_valid_q || m_ready_i);
  assign s_xfer    = (state == ST_LOAD) && s_valid_i;

  // Hold the pointer on the final word so it never steps past the range end.
  assign seq_inc = (beat_load || s_xfer) && !is_last;

  rf_addr_seq #(
    .ADDR_W(ADDR_W)
  ) u_addr_seq (
    .clk       (clk_i),
    .rst       (rst_i),
    .load      (seq_load),
    .inc       (seq_inc),
    .first_addr(first_addr_i),
    .last_addr (last_addr_i),
    .ptr       (ptr),
    .is_last   (is_last)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state     <= ST_IDLE;
      err_q     <= 1'b0;
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start_i) begin
            if (empty_range) begin
              state <= ST_DONE;
              err_q <= 1'b1;
            end else if (mode_t'(mode_i) == MODE_LOAD) begin
              state <= ST_LOAD;
            end else begin
              state <= ST_DUMP;
            end
          end
        end
        ST_DUMP: begin
          if (beat_load) begin
            m_data_q  <= rf_rdata_i;
            m_valid_q <= 1'b1;
            if (is_last) state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (m_ready_i) begin
            m_valid_q <= 1'b0;
            state     <= ST_DONE;
          end
        end
        ST_LOAD: begin
          if (s_xfer && is_last) state <= ST_DONE;
        end
        ST_DONE: begin
          state <= ST_IDLE;
          err_q <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign busy_o = (state == ST_DUMP) || (state == ST_DRAIN) || (state == ST_LOAD);
  assign done_o = (state == ST_DONE);
  assign err_o  = (state == ST_DONE) && err_q;

  assign rf_raddr_o = ((state == ST_DUMP) || (state == ST_DRAIN)) ? ptr : '0;

  // Write port is combinational from the input handshake so the word lands
  // on the transfer edge; register 0 is read-only and is skipped.
  assign s_ready_o  = (state == ST_LOAD);
  assign rf_we_o    = s_xfer && (ptr != '0);
  assign rf_waddr_o = s_xfer ? ptr : '0;
  assign rf_wdata_o = s_xfer ? s_data_i : '0;

  assign m_valid_o = m_valid_q;
  assign m_data_o  = m_data_q;

endmodule

// File: tb/tb_rf_stream_port.sv
module tb_rf_stream_port;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        mode = 1'b0;
  logic [4:0]  first_a = '0;
  logic [4:0]  last_a = '0;
  logic        busy_o, done_o, err_o, rf_we_o;
  logic [4:0]  rf_waddr_o, rf_raddr_o;
  logic [31:0] rf_wdata_o, rf_rdata;
  logic        s_valid = 1'b0;
  logic        s_ready_o;
  logic [31:0] s_data = '0;
  logic        m_valid_o;
  logic        m_ready = 1'b0;
  logic [31:0] m_data_o;

  rf_stream_port dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .start_i     (start),
    .mode_i      (mode),
    .first_addr_i(first_a),
    .last_addr_i (last_a),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .err_o       (err_o),
    .rf_we_o     (rf_we_o),
    .rf_waddr_o  (rf_waddr_o),
    .rf_wdata_o  (rf_wdata_o),
    .rf_raddr_o  (rf_raddr_o),
    .rf_rdata_i  (rf_rdata),
    .s_valid_i   (s_valid),
    .s_ready_o   (s_ready_o),
    .s_data_i    (s_data),
    .m_valid_o   (m_valid_o),
    .m_ready_i   (m_ready),
    .m_data_o    (m_data_o)
  );

  always #5 clk = ~clk;

  // Register file environment: synchronous write, combinational read, x0 = 0.
  logic [31:0] rf_mem [32];
  logic        preload = 1'b0;
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 32; i++) rf_mem[i[4:0]] <= (i == 0) ? 32'h0 : 32'h1000 + 32'(i);
    end else if (rf_we_o && rf_waddr_o != 5'd0) begin
      rf_mem[rf_waddr_o] <= rf_wdata_o;
    end
  end
  assign rf_rdata = (rf_raddr_o == 5'd0) ? 32'h0 : rf_mem[rf_raddr_o];

  // Reference model: expected register image, expected beats, expected writes.
  logic [31:0] gold [32];
  logic [31:0] exp_beats [$];
  logic [31:0] seen [$];
  logic [36:0] exp_writes [$];
  logic [31:0] ld_words [$];

  int checks = 0;
  int errors = 0;
  int hs_total = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: actual=timeout required=done_o", name);
  endtask

  // Per-cycle compare against the stream/write rules.
  logic        prev_stall = 1'b0;
  logic [31:0] prev_data = '0;
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (m_valid_o && m_ready) begin
        if (exp_beats.size() == 0) chk("beat_unexpected", 64'(m_data_o), 64'hDEAD_BEEF_0000_0000);
        else chk("beat_data", 64'(m_data_o), 64'(exp_beats.pop_front()));
        seen.push_back(m_data_o);
        hs_total++;
      end
      if (prev_stall) chk("stall_hold", 64'({m_valid_o, m_data_o}), 64'({1'b1, prev_data}));
      prev_stall = m_valid_o && !m_ready;
      prev_data  = m_data_o;
      if (rf_we_o) begin
        if (exp_writes.size() == 0) chk("write_unexpected", 64'({rf_waddr_o, rf_wdata_o}), 64'hDEAD_BEEF_0000_0000);
        else chk("write_addr_data", 64'({rf_waddr_o, rf_wdata_o}), 64'(exp_writes.pop_front()));
      end
      chk("we_without_xfer", 64'(rf_we_o && !(s_valid && s_ready_o)), 64'h0);
      if (!busy_o) chk("idle_quiet", 64'({m_valid_o, s_ready_o, rf_raddr_o}), 64'h0);
      chk("err_without_done", 64'(err_o && !done_o), 64'h0);
    end
  end

  task automatic all_zero(input string name);
    chk(name, 64'({busy_o, done_o, err_o, rf_we_o, s_ready_o, m_valid_o, rf_waddr_o, rf_raddr_o}), 64'h0);
    chk(name, {rf_wdata_o, m_data_o}, 64'h0);
  endtask

  task automatic do_start(input logic md, input logic [4:0] f, input logic [4:0] l);
    @(posedge clk); #1;
    start = 1'b1; mode = md; first_a = f; last_a = l;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic check_mem();
    int bad;
    bad = 0;
    for (int i = 0; i < 32; i++) if (rf_mem[i[4:0]] !== gold[i[4:0]]) bad++;
    chk("mem_image_mismatches", 64'(bad), 64'h0);
  endtask

  // rmode: 0 ready high, 1 ready toggles, 2 random ready, 3 stall then ready
  // with a stray start pulse while busy.
  task automatic run_dump(input logic [4:0] f, input logic [4:0] l, input int rmode, output int cyc);
    int len;
    len = int'(l) - int'(f) + 1;
    exp_beats.delete();
    seen.delete();
    for (int k = 0; k < len; k++) exp_beats.push_back(gold[f + k[4:0]]);
    m_ready = (rmode == 0 || rmode == 1);
    do_start(1'b0, f, l);
    cyc = 0;
    while (1) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) chk("dump_busy_after_start", 64'(busy_o), 64'h1);
      if (done_o) break;
      if (cyc > 400) begin timeout("dump_done"); break; end
      @(posedge clk); #1;
      case (rmode)
        0: m_ready = 1'b1;
        1: m_ready = ~m_ready;
        2: m_ready = 1'($urandom_range(0, 1));
        default: begin
          m_ready = (cyc >= 4);
          start   = (cyc == 2);
          mode    = 1'b1;
          first_a = 5'd0;
          last_a  = 5'd1;
        end
      endcase
    end
    start = 1'b0;
    chk("dump_err", 64'(err_o), 64'h0);
    chk("dump_beats_left", 64'(exp_beats.size()), 64'h0);
    chk("dump_beat_count", 64'(seen.size()), 64'(len));
    @(negedge clk);
    chk("dump_done_pulse_len", 64'(done_o), 64'h0);
    m_ready = 1'b0;
  endtask

  // vmode: 0 valid held high, 1 random valid gaps. Words come from ld_words.
  task automatic run_load(input logic [4:0] f, input logic [4:0] l, input int vmode, output int cyc);
    int len, idx, nx;
    logic hs;
    logic [4:0] a;
    len = int'(l) - int'(f) + 1;
    exp_writes.delete();
    for (int k = 0; k < len; k++) begin
      a = f + k[4:0];
      if (a != 5'd0) begin
        exp_writes.push_back({a, ld_words[k]});
        gold[a] = ld_words[k];
      end
    end
    idx = 0; nx = 0;
    s_valid = 1'b0;
    do_start(1'b1, f, l);
    cyc = 0;
    while (1) begin
      s_valid = (idx < len) && (vmode == 0 || $urandom_range(0, 3) != 0);
      s_data  = (idx < len) ? ld_words[idx] : $urandom;
      @(negedge clk);
      cyc++;
      if (cyc == 1) chk("load_busy_after_start", 64'(busy_o), 64'h1);
      if (done_o) break;
      if (cyc > 400) begin timeout("load_done"); break; end
      hs = s_valid && s_ready_o;
      if (hs) nx++;
      @(posedge clk); #1;
      if (hs) idx++;
    end
    s_valid = 1'b0;
    chk("load_err", 64'(err_o), 64'h0);
    chk("load_xfer_count", 64'(nx), 64'(len));
    chk("load_writes_left", 64'(exp_writes.size()), 64'h0);
    chk("load_ready_after_done", 64'(s_ready_o), 64'h0);
    @(negedge clk);
    chk("load_done_pulse_len", 64'(done_o), 64'h0);
  endtask

  initial begin
    int cyc, base;
    logic [4:0] f, l;
    for (int i = 0; i < 32; i++) gold[i[4:0]] = (i == 0) ? 32'h0 : 32'h1000 + 32'(i);

    repeat (3) @(negedge clk);
    all_zero("reset_outputs");
    @(posedge clk); #1 preload = 1'b1;
    @(posedge clk); #1 preload = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    all_zero("post_reset_outputs");

    // Full dump, ready always high.
    run_dump(5'd0, 5'd31, 0, cyc);
    chk("full_dump_done_cycle", 64'(cyc), 64'd34);
    if (seen.size() == 32) begin
      chk("full_dump_x0", 64'(seen[0]), 64'h0);
      chk("full_dump_x1", 64'(seen[1]), 64'h1001);
      chk("full_dump_x31", 64'(seen[31]), 64'h101F);
    end

    // Backpressure with toggling ready.
    run_dump(5'd5, 5'd7, 1, cyc);
    if (seen.size() == 3) begin
      chk("bp_x5", 64'(seen[0]), 64'h1005);
      chk("bp_x7", 64'(seen[2]), 64'h1007);
    end

    // Load over x0.
    ld_words = '{32'hAAAA, 32'hBBBB, 32'hCCCC};
    run_load(5'd0, 5'd2, 0, cyc);
    chk("load_x0_done_cycle", 64'(cyc), 64'd4);
    chk("load_x1", 64'(rf_mem[1]), 64'hBBBB);
    chk("load_x2", 64'(rf_mem[2]), 64'hCCCC);
    check_mem();
    run_dump(5'd0, 5'd2, 0, cyc);
    if (seen.size() == 3) begin
      chk("dump_after_load_x0", 64'(seen[0]), 64'h0);
      chk("dump_after_load_x1", 64'(seen[1]), 64'hBBBB);
      chk("dump_after_load_x2", 64'(seen[2]), 64'hCCCC);
    end

    // Upper boundary with input gaps.
    ld_words = '{$urandom, $urandom};
    run_load(5'd30, 5'd31, 1, cyc);
    chk("upper_x0_untouched", 64'(rf_mem[0]), 64'h0);
    chk("upper_x31", 64'(rf_mem[31]), 64'(ld_words[1]));
    check_mem();

    // Empty range.
    do_start(1'b0, 5'd9, 5'd4);
    @(negedge clk);
    chk("empty_flags", 64'({done_o, err_o, busy_o}), 64'b110);
    @(negedge clk);
    chk("empty_flags_after", 64'({done_o, err_o, busy_o}), 64'b000);

    // Randomised operations.
    for (int t = 0; t < 10; t++) begin
      f = 5'($urandom_range(0, 31));
      l = 5'($urandom_range(31, int'(f)));
      if ($urandom_range(0, 1) == 1) begin
        ld_words.delete();
        for (int k = 0; k <= int'(l) - int'(f); k++) ld_words.push_back($urandom);
        run_load(f, l, 1, cyc);
      end else begin
        run_dump(f, l, 2, cyc);
      end
      check_mem();
    end

    // Abort after three beats with reset.
    exp_beats.delete();
    for (int k = 0; k < 32; k++) exp_beats.push_back(gold[k[4:0]]);
    m_ready = 1'b1;
    base = hs_total;
    do_start(1'b0, 5'd0, 5'd31);
    cyc = 0;
    while (hs_total < base + 3 && cyc < 100) begin
      @(negedge clk); #1;
      cyc++;
    end
    if (cyc >= 100) timeout("abort_beats");
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    all_zero("abort_async_outputs");
    exp_beats.delete();
    m_ready = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    all_zero("abort_after_release");
    check_mem();

    // Start ignored while busy, then normal completion.
    run_dump(5'd5, 5'd7, 3, cyc);
    if (seen.size() == 3) chk("retry_x6", 64'(seen[1]), 64'(gold[6]));
    run_dump(5'd0, 5'd31, 2, cyc);
    check_mem();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
